dmem_wait_ctrl: RTL and testbench

Parametrised single-port data memory with a valid/ready request channel, a one-cycle response pulse, configurable wait states, byte-lane write strobes, and an address-error flag. It replaces the fixed zero-wait synchronous data memory model next to `riscv_3stage`. It lets the core's load/store path be exercised against slower memories and partial-word stores. It is synthesisable and is also used as the bench memory.

---
 rtl/dmem_wait_ctrl.sv | 127 ++++++++++++
 tb/tb_dmem_wait_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wait_ctrl.sv
// Single-port data memory behind a valid/ready request channel with
// configurable wait states, byte-lane strobes and an address-error response.
module dmem_wait_ctrl #(
  parameter int DEPTH   = 128,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);
  localparam bit BYPASS = (LATENCY == 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF) - 64'd1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [3:0]         cnt, cnt_nxt;
  logic               accept, commit;
  logic               req_err;
  logic [IW-1:0]      req_idx;

  logic               we_q, err_q;
  logic [IW-1:0]      idx_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [NB-1:0]      wstrb_q;

  logic               c_we, c_err;
  logic [IW-1:0]      c_idx;
  logic [DATA_W-1:0]  c_wdata;
  logic [NB-1:0]      c_wstrb;

  logic [DATA_W-1:0]  mem [DEPTH];

  assign req_ready = (state != WAIT);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid & req_ready;
  assign req_idx   = req_addr[IW+OFF-1:OFF];
  assign req_err   = ((req_addr & OFF_MASK) != '0) || ((req_addr >> (IW + OFF)) != '0);

  // Zero-wait commits straight from the request bus; otherwise from the capture regs.
  assign c_we    = BYPASS ? req_we    : we_q;
  assign c_err   = BYPASS ? req_err   : err_q;
  assign c_idx   = BYPASS ? req_idx   : idx_q;
  assign c_wdata = BYPASS ? req_wdata : wdata_q;
  assign c_wstrb = BYPASS ? req_wstrb : wstrb_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    unique case (state)
      IDLE, RESP: begin
        if (accept) begin
          if (BYPASS) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(LATENCY - 2);
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_q    <= req_we;
        err_q   <= req_err;
        idx_q   <= req_idx;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
      // Response fields are only nonzero for the RESP cycle that follows a commit.
      rsp_rdata <= (commit && !c_we && !c_err) ? mem[c_idx] : '0;
      rsp_err   <= commit && c_err;
    end
  end

  // Array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (commit && c_we && !c_err) begin
      for (int b = 0; b < NB; b++) begin
        if (c_wstrb[b]) mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Self-checking bench: zero-wait instance scored against a word model,
// plus LATENCY=4 and LATENCY=3 instances for wait-state and reset timing.
module tb_dmem_wait_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v1 = 0, we1 = 0, rdy1, rv1, re1;
  logic [31:0] a1 = 0, wd1 = 0, rd1;
  logic [3:0]  ws1 = 0;
  logic        v4 = 0, we4 = 0, rdy4, rv4, re4;
  logic [31:0] a4 = 0, wd4 = 0, rd4;
  logic [3:0]  ws4 = 0;
  logic        v3 = 0, we3 = 0, rdy3, rv3, re3;
  logic [31:0] a3 = 0, wd3 = 0, rd3;
  logic [3:0]  ws3 = 0;

  dmem_wait_ctrl #(.DEPTH(128), .DATA_W(32), .ADDR_W(32), .LATENCY(1)) u_l1 (
    .clk(clk), .resetn(rst_n), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
    .req_addr(a1), .req_wdata(wd1), .req_wstrb(ws1),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1));

  dmem_wait_ctrl #(.DEPTH(128), .DATA_W(32), .ADDR_W(32), .LATENCY(4)) u_l4 (
    .clk(clk), .resetn(rst_n), .req_valid(v4), .req_ready(rdy4), .req_we(we4),
    .req_addr(a4), .req_wdata(wd4), .req_wstrb(ws4),
    .rsp_valid(rv4), .rsp_rdata(rd4), .rsp_err(re4));

  dmem_wait_ctrl #(.DEPTH(128), .DATA_W(32), .ADDR_W(32), .LATENCY(3)) u_l3 (
    .clk(clk), .resetn(rst_n), .req_valid(v3), .req_ready(rdy3), .req_we(we3),
    .req_addr(a3), .req_wdata(wd3), .req_wstrb(ws3),
    .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(re3));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mdl [128];
  int          n_chk = 0, n_pass = 0;
  int          n_rsp1 = 0, run = 0, last_run = 0;

  // Scoreboard consumer for the zero-wait instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rv1) begin
        n_rsp1++;
        run++;
        n_chk++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected_rsp: got rdata=%h err=%b, required no response", rd1, re1);
        end else begin
          mon_e = sb.pop_front();
          if (rd1 !== mon_e.rdata || re1 !== mon_e.err)
            $display("FAIL sb_rsp addr=%h: got rdata=%h err=%b, required rdata=%h err=%b",
                     mon_e.addr, rd1, re1, mon_e.rdata, mon_e.err);
          else n_pass++;
        end
      end else begin
        if (run > 0) last_run = run;
        run = 0;
      end
    end
  end

  // Drives one request on the zero-wait port for one cycle; call at posedge+1.
  task automatic issue1(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws);
    exp_t       e;
    logic [6:0] idx;
    idx     = addr[8:2];
    e.addr  = addr;
    e.err   = (addr[1:0] != 2'b00) || (addr >= 32'h200);
    e.rdata = '0;
    if (!e.err) begin
      if (we) begin
        for (int b = 0; b < 4; b++) if (ws[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        e.rdata = mdl[idx];
      end
    end
    sb.push_back(e);
    v1 = 1'b1; we1 = we; a1 = addr; wd1 = wd; ws1 = ws;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (rdy1 !== 1'b1) $display("FAIL reset_ready1: got %b, required 1", rdy1); else n_pass++;
    n_chk++; if (rv1 !== 1'b0) $display("FAIL reset_valid1: got %b, required 0", rv1); else n_pass++;
    n_chk++; if (rd1 !== 32'h0) $display("FAIL reset_rdata1: got %h, required 0", rd1); else n_pass++;
    n_chk++; if (re1 !== 1'b0) $display("FAIL reset_err1: got %b, required 0", re1); else n_pass++;
    n_chk++; if (rdy4 !== 1'b1) $display("FAIL reset_ready4: got %b, required 1", rdy4); else n_pass++;
    n_chk++; if (rv4 !== 1'b0) $display("FAIL reset_valid4: got %b, required 0", rv4); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_strobe();
    int n0;
    n0 = n_rsp1;
    issue1(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    issue1(1'b1, 32'h10, 32'h000000AA, 4'h1);
    issue1(1'b0, 32'h10, 32'h0, 4'h0);
    v1 = 1'b0;
    @(negedge clk);
    n_chk++;
    if (rd1 !== 32'hDEADBEAA || re1 !== 1'b0)
      $display("FAIL strobe_read: got rdata=%h err=%b, required DEADBEAA err=0", rd1, re1);
    else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (last_run != 3) $display("FAIL strobe_pulse_run: got %0d, required 3", last_run); else n_pass++;
    n_chk++; if (n_rsp1 - n0 != 3) $display("FAIL strobe_rsp_count: got %0d, required 3", n_rsp1 - n0); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_errors();
    issue1(1'b1, 32'h0,   32'h00000005, 4'hF);
    issue1(1'b1, 32'h2,   32'hFFFFFFFF, 4'hF);
    issue1(1'b1, 32'h200, 32'hFFFFFFFF, 4'hF);
    issue1(1'b1, 32'h0,   32'hFFFFFFFF, 4'h0);
    issue1(1'b0, 32'h0,   32'h0, 4'h0);
    v1 = 1'b0;
    @(negedge clk);
    n_chk++;
    if (rd1 !== 32'h5 || re1 !== 1'b0)
      $display("FAIL err_word0_unchanged: got rdata=%h err=%b, required 00000005 err=0", rd1, re1);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] wr_addrs[16];
    int n0;
    n0 = n_rsp1;
    for (int i = 0; i < 16; i++) begin
      wr_addrs[i] = {25'd0, 5'($urandom_range(31)), 2'b00};
      issue1(1'b1, wr_addrs[i], $urandom, 4'hF);
    end
    for (int i = 0; i < 16; i++) issue1(1'b0, wr_addrs[$urandom_range(15)], 32'h0, 4'h0);
    v1 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (n_rsp1 - n0 != 32) $display("FAIL b2b_rsp_count: got %0d, required 32", n_rsp1 - n0); else n_pass++;
    n_chk++; if (last_run != 32) $display("FAIL b2b_pulse_run: got %0d, required 32", last_run); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_wait_states();
    int low_cnt, cyc;
    bit seen;
    v4 = 1'b1; we4 = 1'b1; a4 = 32'h0; wd4 = 32'h5; ws4 = 4'hF;
    @(posedge clk); #1;
    v4 = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = rv4; end
    n_chk++; if (!seen || re4 !== 1'b0) $display("FAIL wait_preload: got seen=%b err=%b, required 1 0", seen, re4); else n_pass++;
    @(posedge clk); #1;
    v4 = 1'b1; we4 = 1'b0; a4 = 32'h0;
    @(posedge clk); #1;
    low_cnt = 0; cyc = 0; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (!rdy4) low_cnt++;
      seen = rv4;
    end
    n_chk++; if (!seen || cyc != 4) $display("FAIL wait_latency: got seen=%b cycles=%0d, required 1 4", seen, cyc); else n_pass++;
    n_chk++; if (low_cnt != 3) $display("FAIL wait_ready_low: got %0d cycles, required 3", low_cnt); else n_pass++;
    n_chk++; if (rd4 !== 32'h5) $display("FAIL wait_rdata: got %h, required 00000005", rd4); else n_pass++;
    n_chk++; if (rdy4 !== 1'b1) $display("FAIL wait_ready_in_resp: got %b, required 1", rdy4); else n_pass++;
    @(posedge clk); #1;
    v4 = 1'b0;
    n_chk++; if (rdy4 !== 1'b0) $display("FAIL wait_second_accept: got ready=%b, required 0", rdy4); else n_pass++;
    cyc = 0; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); cyc++; seen = rv4; end
    n_chk++;
    if (!seen || cyc != 4 || rd4 !== 32'h5)
      $display("FAIL wait_second_rsp: got seen=%b cycles=%0d rdata=%h, required 1 4 00000005", seen, cyc, rd4);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    bit seen;
    int n_seen;
    v3 = 1'b1; we3 = 1'b1; a3 = 32'h8; wd3 = 32'h0000CAFE; ws3 = 4'hF;
    @(posedge clk); #1;
    v3 = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = rv3; end
    n_chk++; if (!seen) $display("FAIL rst_preload: got no response, required one"); else n_pass++;
    @(posedge clk); #1;
    v3 = 1'b1; we3 = 1'b1; a3 = 32'h8; wd3 = 32'h00001234; ws3 = 4'hF;
    @(posedge clk); #1;
    v3 = 1'b0;
    n_chk++; if (rdy3 !== 1'b0) $display("FAIL rst_in_wait: got ready=%b, required 0", rdy3); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (rdy3 !== 1'b1 || rv3 !== 1'b0 || rd3 !== 32'h0 || re3 !== 1'b0)
      $display("FAIL rst_outputs: got ready=%b valid=%b rdata=%h err=%b, required 1 0 0 0", rdy3, rv3, rd3, re3);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_chk++; if (rv3 !== 1'b0 || rdy3 !== 1'b1) $display("FAIL rst_hold: got valid=%b ready=%b, required 0 1", rv3, rdy3); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_seen = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (rv3) n_seen++; end
    n_chk++; if (n_seen != 0) $display("FAIL rst_no_rsp: got %0d responses, required 0", n_seen); else n_pass++;
    @(posedge clk); #1;
    v3 = 1'b1; we3 = 1'b0; a3 = 32'h8;
    @(posedge clk); #1;
    v3 = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = rv3; end
    n_chk++;
    if (!seen || rd3 !== 32'h0000CAFE)
      $display("FAIL rst_prior_value: got seen=%b rdata=%h, required 1 0000CAFE", seen, rd3);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_strobe();
    test_errors();
    test_back_to_back();
    test_wait_states();
    test_mid_reset();
    n_chk++;
    if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending, required 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
